// File: rtl/gun_cursor_pkg.sv
// Shared constants and helpers for the gun_cursor block.
//   POS_W_MIN / POS_W_MAX : legal position width range
//   centre()              : mid-scale position for a given width
//   analog_to_pos()       : signed stick byte -> offset-binary, top w bits
package gun_cursor_pkg;

    localparam int unsigned POS_W_MIN = 4;
    localparam int unsigned POS_W_MAX = 8;

    localparam int unsigned RATE_MIN  = 1;
    localparam int unsigned RATE_MAX  = 15;
    localparam int unsigned ACCEL_MIN = 1;
    localparam int unsigned ACCEL_MAX = 255;

    // Result is right-aligned in 8 bits; the caller truncates to its width.
    function automatic logic [7:0] centre(input int unsigned w);
        return 8'(1 << (w - 1));
    endfunction

    // Flipping the sign bit is the same as adding 128 to a two's complement byte.
    function automatic logic [7:0] analog_to_pos(input logic [7:0] a, input int unsigned w);
        return (a ^ 8'h80) >> (8 - w);
    endfunction

endpackage

// File: rtl/gun_cursor_if.sv
// Bundle of the per-channel joystick inputs and cursor outputs of gun_cursor.
//   master : drives tick, directions, analog stick, abs_mode, recenter
//   slave  : the cursor block; drives gun_h, gun_v, moved
interface gun_cursor_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned POS_W    = 6
);
    logic                      tick;
    logic [CHANNELS-1:0]       dir_left;
    logic [CHANNELS-1:0]       dir_right;
    logic [CHANNELS-1:0]       dir_up;
    logic [CHANNELS-1:0]       dir_down;
    logic [CHANNELS*8-1:0]     analog_x;
    logic [CHANNELS*8-1:0]     analog_y;
    logic [CHANNELS-1:0]       abs_mode;
    logic [CHANNELS-1:0]       recenter;
    logic [CHANNELS*POS_W-1:0] gun_h;
    logic [CHANNELS*POS_W-1:0] gun_v;
    logic [CHANNELS-1:0]       moved;

    modport master (
        output tick, dir_left, dir_right, dir_up, dir_down,
        output analog_x, analog_y, abs_mode, recenter,
        input  gun_h, gun_v, moved
    );

    modport slave (
        input  tick, dir_left, dir_right, dir_up, dir_down,
        input  analog_x, analog_y, abs_mode, recenter,
        output gun_h, gun_v, moved
    );
endinterface

// File: rtl/gun_axis.sv
// One cursor axis: saturating position with rate phase and hold acceleration,
// plus absolute (analog) mapping and recentre.
//   clk_sys, reset : clock, synchronous active-high reset
//   upd            : one-cycle update strobe (tick rising edge)
//   abs_mode       : 1 = follow analog, 0 = relative digital
//   recenter       : force centre, overrides upd
//   minus, plus    : held directions
//   analog         : signed stick byte
//   pos            : registered position
//   changed        : registered flag, pos changed on the last clock
module gun_axis
    import gun_cursor_pkg::*;
#(
    parameter int unsigned POS_W       = 6,
    parameter int unsigned RATE        = 4,
    parameter int unsigned ACCEL_TICKS = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             upd,
    input  logic             abs_mode,
    input  logic             recenter,
    input  logic             minus,
    input  logic             plus,
    input  logic [7:0]       analog,
    output logic [POS_W-1:0] pos,
    output logic             changed
);

    localparam logic [POS_W-1:0] CENTRE  = POS_W'(centre(POS_W));
    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};
    localparam logic [3:0]       PC_LAST = 4'(RATE - 1);
    localparam logic [7:0]       HC_MAX  = 8'(ACCEL_TICKS);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [3:0]       pc_q, pc_d;
    logic [7:0]       hc_q, hc_d;
    logic             changed_q, changed_d;

    logic             active;
    logic             step;
    logic [POS_W-1:0] abs_pos;

    assign active  = plus ^ minus;
    // Full speed once held long enough, otherwise one step per RATE ticks
    // starting with the very first tick of a press.
    assign step    = (hc_q >= HC_MAX) | (pc_q == 4'd0);
    assign abs_pos = POS_W'(analog_to_pos(analog, POS_W));

    always_comb begin
        pos_d = pos_q;
        pc_d  = pc_q;
        hc_d  = hc_q;
        if (recenter) begin
            pos_d = CENTRE;
            pc_d  = 4'd0;
            hc_d  = 8'd0;
        end else if (upd) begin
            if (abs_mode) begin
                pos_d = abs_pos;
                pc_d  = 4'd0;
                hc_d  = 8'd0;
            end else if (active) begin
                pc_d = (pc_q == PC_LAST) ? 4'd0 : pc_q + 4'd1;
                hc_d = (hc_q >= HC_MAX) ? HC_MAX : hc_q + 8'd1;
                if (step) begin
                    if (plus) begin
                        if (pos_q != POS_MAX) pos_d = pos_q + POS_W'(1);
                    end else begin
                        if (pos_q != '0) pos_d = pos_q - POS_W'(1);
                    end
                end
            end else begin
                // Idle or both pressed: acceleration restarts on the next press.
                pc_d = 4'd0;
                hc_d = 8'd0;
            end
        end
        changed_d = (pos_d != pos_q);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos_q     <= CENTRE;
            pc_q      <= 4'd0;
            hc_q      <= 8'd0;
            changed_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            pc_q      <= pc_d;
            hc_q      <= hc_d;
            changed_q <= changed_d;
        end
    end

    assign pos     = pos_q;
    assign changed = changed_q;

endmodule

// File: rtl/gun_cursor.sv
// Multi-channel joystick-to-lightgun cursor integrator.
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : gun_cursor_if slave; tick, directions, analog, abs_mode,
//             recenter in; gun_h, gun_v, moved out
// Owns tick edge detection and instantiates one gun_axis per axis per channel.
module gun_cursor
    import gun_cursor_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned POS_W       = 6,
    parameter int unsigned RATE        = 4,
    parameter int unsigned ACCEL_TICKS = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    gun_cursor_if.slave bus
);

    if (POS_W < POS_W_MIN || POS_W > POS_W_MAX) begin : g_bad_pos_w
        $error("gun_cursor: POS_W out of range 4..8");
    end
    if (RATE < RATE_MIN || RATE > RATE_MAX) begin : g_bad_rate
        $error("gun_cursor: RATE out of range 1..15");
    end
    if (ACCEL_TICKS < ACCEL_MIN || ACCEL_TICKS > ACCEL_MAX) begin : g_bad_accel
        $error("gun_cursor: ACCEL_TICKS out of range 1..255");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("gun_cursor: CHANNELS must be at least 1");
    end

    logic tick_q, tick_d;
    logic upd;

    logic [CHANNELS*POS_W-1:0] gun_h;
    logic [CHANNELS*POS_W-1:0] gun_v;
    logic [CHANNELS-1:0]       chg_h;
    logic [CHANNELS-1:0]       chg_v;

    always_comb begin
        tick_d = bus.tick;
    end

    // Loaded with tick during reset too, so a tick already high at reset
    // release is not seen as an edge.
    always_ff @(posedge clk_sys) begin
        tick_q <= tick_d;
    end

    assign upd = bus.tick & ~tick_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gun_axis #(
            .POS_W       (POS_W),
            .RATE        (RATE),
            .ACCEL_TICKS (ACCEL_TICKS)
        ) u_axis_h (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .upd      (upd),
            .abs_mode (bus.abs_mode[c]),
            .recenter (bus.recenter[c]),
            .minus    (bus.dir_left[c]),
            .plus     (bus.dir_right[c]),
            .analog   (bus.analog_x[8*c +: 8]),
            .pos      (gun_h[POS_W*c +: POS_W]),
            .changed  (chg_h[c])
        );

        gun_axis #(
            .POS_W       (POS_W),
            .RATE        (RATE),
            .ACCEL_TICKS (ACCEL_TICKS)
        ) u_axis_v (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .upd      (upd),
            .abs_mode (bus.abs_mode[c]),
            .recenter (bus.recenter[c]),
            .minus    (bus.dir_up[c]),
            .plus     (bus.dir_down[c]),
            .analog   (bus.analog_y[8*c +: 8]),
            .pos      (gun_v[POS_W*c +: POS_W]),
            .changed  (chg_v[c])
        );
    end

    assign bus.gun_h = gun_h;
    assign bus.gun_v = gun_v;
    // Both flags are registered, so moved has no combinational input path.
    assign bus.moved = chg_h | chg_v;

endmodule

// File: tb/tb_gun_cursor.sv
// Scoreboard bench for gun_cursor: every driven cycle pushes the reference
// model's expected outputs; a monitor pops and compares after each clock.
module tb_gun_cursor;

    localparam int unsigned CH   = 2;
    localparam int unsigned PW   = 6;
    localparam int unsigned RATE = 4;
    localparam int unsigned ACC  = 16;
    localparam int          CENTRE = 32;
    localparam int          PMAX   = 63;

    typedef struct packed {
        logic [CH*PW-1:0] h;
        logic [CH*PW-1:0] v;
        logic [CH-1:0]    moved;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gun_cursor_if #(.CHANNELS(CH), .POS_W(PW)) bus ();

    gun_cursor #(
        .CHANNELS    (CH),
        .POS_W       (PW),
        .RATE        (RATE),
        .ACCEL_TICKS (ACC)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    // Reference model: pos per axis and the length of the current held run.
    int   mpos[2*CH];
    int   mrun[2*CH];
    logic m_tick_prev = 1'b0;

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int clamp(int p);
        if (p < 0) return 0;
        if (p > PMAX) return PMAX;
        return p;
    endfunction

    task automatic model_step();
        exp_t e;
        logic upd;
        upd = bus.tick & ~m_tick_prev;
        e = '0;
        for (int c = 0; c < int'(CH); c++) begin
            for (int ax = 0; ax < 2; ax++) begin
                int i;
                int old;
                int a;
                logic mi;
                logic pl;
                i   = 2 * c + ax;
                old = mpos[i];
                mi  = (ax == 0) ? bus.dir_left[c]  : bus.dir_up[c];
                pl  = (ax == 0) ? bus.dir_right[c] : bus.dir_down[c];
                a   = (ax == 0) ? int'($signed(bus.analog_x[8*c +: 8]))
                                : int'($signed(bus.analog_y[8*c +: 8]));
                if (reset || bus.recenter[c]) begin
                    mpos[i] = CENTRE;
                    mrun[i] = 0;
                end else if (upd) begin
                    if (bus.abs_mode[c]) begin
                        mpos[i] = (a + 128) >> (8 - PW);
                        mrun[i] = 0;
                    end else if (pl ^ mi) begin
                        if (mrun[i] >= int'(ACC) || (mrun[i] % int'(RATE)) == 0)
                            mpos[i] = clamp(mpos[i] + (pl ? 1 : -1));
                        mrun[i]++;
                    end else begin
                        mrun[i] = 0;
                    end
                end
                if (!reset && mpos[i] != old) e.moved[c] = 1'b1;
            end
            e.h[c*PW +: PW] = PW'(mpos[2*c]);
            e.v[c*PW +: PW] = PW'(mpos[2*c+1]);
        end
        m_tick_prev = bus.tick;
        q.push_back(e);
    endtask

    // Inputs are set at the negedge before calling; returns at the next negedge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("mon_gun_h", int'(bus.gun_h), int'(e.h));
            check("mon_gun_v", int'(bus.gun_v), int'(e.v));
            check("mon_moved", int'(bus.moved), int'(e.moved));
        end
    end

    initial begin
        bus.tick      = 1'b1;
        bus.dir_left  = '0;
        bus.dir_right = '0;
        bus.dir_up    = '0;
        bus.dir_down  = '0;
        bus.analog_x  = '0;
        bus.analog_y  = '0;
        bus.abs_mode  = '0;
        bus.recenter  = '0;
        for (int i = 0; i < int'(2*CH); i++) begin
            mpos[i] = CENTRE;
            mrun[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
        step(); step(); step();
        check("reset_h0", int'(bus.gun_h[PW-1:0]), CENTRE);
        check("reset_v1", int'(bus.gun_v[2*PW-1:PW]), CENTRE);
        check("reset_moved", int'(bus.moved), 0);

        // Tick still high at release: no edge.
        reset = 1'b0;
        bus.dir_right = 2'b01;
        step();
        check("no_edge_release", int'(bus.gun_h[PW-1:0]), CENTRE);
        bus.tick = 1'b0;
        step();

        // Held right: steps at ticks 1,5,9,13 then every tick from 17.
        for (int t = 1; t <= 20; t++) begin
            bus.tick = 1'b1;
            step();
            check("accel_moved", int'(bus.moved[0]), (t % 4 == 1 || t >= 17) ? 1 : 0);
            if (t == 1)  check("accel_t1",  int'(bus.gun_h[PW-1:0]), 33);
            if (t == 13) check("accel_t13", int'(bus.gun_h[PW-1:0]), 36);
            if (t == 20) check("accel_t20", int'(bus.gun_h[PW-1:0]), 40);
            bus.tick = 1'b0;
            step();
        end
        bus.dir_right = '0;
        do_tick();

        // Saturation at 0.
        bus.abs_mode[0] = 1'b1;
        bus.analog_x[7:0] = 8'h84;
        do_tick();
        check("abs_to_1", int'(bus.gun_h[PW-1:0]), 1);
        bus.abs_mode[0] = 1'b0;
        bus.dir_left[0] = 1'b1;
        do_tick();
        check("sat_low", int'(bus.gun_h[PW-1:0]), 0);
        for (int t = 0; t < 6; t++) begin
            bus.tick = 1'b1;
            step();
            check("sat_low_hold", int'(bus.gun_h[PW-1:0]), 0);
            check("sat_low_nomove", int'(bus.moved[0]), 0);
            bus.tick = 1'b0;
            step();
        end
        bus.dir_left[0] = 1'b0;

        // Saturation at 63.
        bus.abs_mode[0] = 1'b1;
        bus.analog_x[7:0] = 8'h7f;
        do_tick();
        bus.abs_mode[0] = 1'b0;
        bus.dir_right[0] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            bus.tick = 1'b1;
            step();
            check("sat_high_hold", int'(bus.gun_h[PW-1:0]), PMAX);
            check("sat_high_nomove", int'(bus.moved[0]), 0);
            bus.tick = 1'b0;
            step();
        end
        bus.dir_right[0] = 1'b0;

        // Both held: no motion; then right alone steps immediately.
        bus.abs_mode[0] = 1'b1;
        bus.analog_x[7:0] = 8'h00;
        do_tick();
        bus.abs_mode[0] = 1'b0;
        bus.dir_left[0]  = 1'b1;
        bus.dir_right[0] = 1'b1;
        for (int t = 0; t < 5; t++) do_tick();
        check("both_held", int'(bus.gun_h[PW-1:0]), CENTRE);
        bus.dir_left[0] = 1'b0;
        bus.tick = 1'b1;
        step();
        check("right_after_both", int'(bus.gun_h[PW-1:0]), 33);
        bus.tick = 1'b0;
        step();
        bus.dir_right[0] = 1'b0;

        // Absolute sweep on ch0 while ch1 moves relatively.
        bus.abs_mode[0]  = 1'b1;
        bus.dir_right[1] = 1'b1;
        bus.analog_x[7:0] = 8'h80;
        do_tick();
        check("abs_m128", int'(bus.gun_h[PW-1:0]), 0);
        bus.analog_x[7:0] = 8'h00;
        do_tick();
        check("abs_zero", int'(bus.gun_h[PW-1:0]), 32);
        bus.analog_x[7:0] = 8'h7f;
        do_tick();
        check("abs_p127", int'(bus.gun_h[PW-1:0]), 63);
        bus.abs_mode[0]  = 1'b0;
        bus.dir_right[1] = 1'b0;

        // Recentre beats a tick edge with right held.
        bus.dir_right[0] = 1'b1;
        bus.recenter[0]  = 1'b1;
        bus.tick = 1'b1;
        step();
        check("recenter_h", int'(bus.gun_h[PW-1:0]), CENTRE);
        bus.tick = 1'b0;
        step();
        bus.recenter[0] = 1'b0;

        // Reset in the middle of acceleration.
        for (int t = 0; t < 10; t++) do_tick();
        reset = 1'b1;
        step(); step();
        check("reset_mid_h", int'(bus.gun_h[PW-1:0]), CENTRE);
        reset = 1'b0;
        step();
        bus.tick = 1'b1;
        step();
        check("post_reset_step", int'(bus.gun_h[PW-1:0]), 33);
        bus.tick = 1'b0;
        step();
        bus.dir_right = '0;

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            bus.tick      = 1'($urandom_range(0, 1));
            bus.dir_left  = CH'($urandom);
            bus.dir_right = CH'($urandom);
            bus.dir_up    = CH'($urandom);
            bus.dir_down  = CH'($urandom);
            bus.analog_x  = (CH*8)'($urandom);
            bus.analog_y  = (CH*8)'($urandom);
            if ($urandom_range(0, 19) == 0) bus.abs_mode = CH'($urandom);
            bus.recenter  = ($urandom_range(0, 29) == 0) ? CH'($urandom) : '0;
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
